iob_eth_rx_ctrl: RTL

System-clock-domain controller for the Ethernet receive path. Programs the receiver's expected payload length, detects completed frames via the receiver's `data_rcvd` flag, arbitrates the single frame-buffer read port between a CPU register port and a DMA byte stream, and returns `rcv_ack` so the receiver can re-arm. Sits between the CSR/DMA fabric and the RX_CLK-domain receiver plus its frame buffer.

---
 rtl/iob_eth_rx_ctrl_if.sv | 29 ++
 rtl/iob_eth_rx_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_rx_ctrl_if.sv
// Frame-buffer read port, CPU byte-read port and DMA byte stream of the RX controller.
// master: the controller side; slave: the fabric/buffer side.
interface iob_eth_rx_ctrl_if #(
  parameter int BUF_AW = 11
) ();
  logic              cpu_req;
  logic [BUF_AW-1:0] cpu_addr;
  logic              cpu_rvalid;
  logic [7:0]        cpu_rdata;

  logic [BUF_AW-1:0] buf_addr;
  logic              buf_rd;
  logic [7:0]        buf_rdata;

  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (
    input  cpu_req, cpu_addr, buf_rdata, m_ready,
    output cpu_rvalid, cpu_rdata, buf_addr, buf_rd, m_data, m_valid, m_last
  );

  modport slave (
    output cpu_req, cpu_addr, buf_rdata, m_ready,
    input  cpu_rvalid, cpu_rdata, buf_addr, buf_rd, m_data, m_valid, m_last
  );
endinterface

// File: rtl/iob_eth_rx_ctrl.sv
// Ethernet RX system-side controller: arms the receiver, arbitrates buffer reads (CPU vs DMA), acks frames.
// Define IOB_ETH_RX_AUTO_REARM_EN to return to ARMED after each ack instead of IDLE.
//
// state | meaning
// IDLE  | waiting for rx_start to latch the payload length
// ARMED | receiver armed, waiting for synchronized data_rcvd
// READY | frame in buffer; CPU and DMA may read it
// ACK   | rcv_ack held high until the receiver drops data_rcvd
module iob_eth_rx_ctrl #(
  parameter int BUF_AW = 11,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      rx_nbytes_cfg,
  input  logic             rx_start,
  input  logic             rx_release,
  input  logic             dma_en,
  output logic [10:0]      nbytes,
  input  logic             data_rcvd,
  output logic             rcv_ack,
  output logic             rx_ready,
  output logic [CNT_W-1:0] frame_cnt,
  iob_eth_rx_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, ARMED, READY, ACK} state_t;

  localparam logic [11:0] HDR_LEN = 12'd14;

  state_t            state_q, state_d;
  logic              rcvd_m_q, rcvd_m_d, rcvd_s_q, rcvd_s_d;
  logic [10:0]       nbytes_q, nbytes_d;
  logic              rcv_ack_q, rcv_ack_d;
  logic              rx_ready_q, rx_ready_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              buf_rd_q, buf_rd_d;
  logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
  logic              rd_cpu_q, rd_cpu_d;
  logic              rd_last_q, rd_last_d;
  logic              rsp_q, rsp_d;
  logic              rsp_cpu_q, rsp_cpu_d;
  logic              rsp_last_q, rsp_last_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [7:0]        m_data_q, m_data_d;
  logic [11:0]       dma_ptr_q, dma_ptr_d;

  logic [11:0] last_addr;
  logic        cpu_busy, cpu_issue, dma_issue, beat_acc;

  always_comb begin
    state_d      = state_q;
    rcvd_m_d     = data_rcvd;
    rcvd_s_d     = rcvd_m_q;
    nbytes_d     = nbytes_q;
    frame_cnt_d  = frame_cnt_q;
    buf_addr_d   = buf_addr_q;
    cpu_rdata_d  = cpu_rdata_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    m_data_d     = m_data_q;
    dma_ptr_d    = dma_ptr_q;

    last_addr = {1'b0, nbytes_q} + 12'd13;
    beat_acc  = m_valid_q & bus.m_ready;

    // The CPU holds cpu_req through its own rvalid cycle, so stay busy until then.
    cpu_busy  = (buf_rd_q & rd_cpu_q) | (rsp_q & rsp_cpu_q) | cpu_rvalid_q;
    cpu_issue = bus.cpu_req & ~cpu_busy;
    dma_issue = (state_q == READY) & dma_en & ~buf_rd_q & ~rsp_q & ~m_valid_q
                & ~bus.cpu_req & (dma_ptr_q <= last_addr);

    buf_rd_d  = cpu_issue | dma_issue;
    rd_cpu_d  = cpu_issue;
    rd_last_d = dma_issue & (dma_ptr_q == last_addr);
    if (cpu_issue) begin
      buf_addr_d = bus.cpu_addr;
    end else if (dma_issue) begin
      buf_addr_d = dma_ptr_q[BUF_AW-1:0];
      dma_ptr_d  = dma_ptr_q + 12'd1;
    end

    rsp_d      = buf_rd_q;
    rsp_cpu_d  = rd_cpu_q;
    rsp_last_d = rd_last_q;

    cpu_rvalid_d = rsp_q & rsp_cpu_q;
    if (rsp_q & rsp_cpu_q) cpu_rdata_d = bus.buf_rdata;

    unique case (state_q)
      IDLE: begin
        if (rx_start) begin
          nbytes_d = rx_nbytes_cfg;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (rcvd_s_q) begin
          state_d   = READY;
          dma_ptr_d = HDR_LEN;
        end
      end
      READY: begin
        if (rx_release | (dma_en & beat_acc & m_last_q)) state_d = ACK;
      end
      ACK: begin
        if (!rcvd_s_q) begin
          frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef IOB_ETH_RX_AUTO_REARM_EN
          state_d = ARMED;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_acc) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    if (rsp_q & ~rsp_cpu_q) begin
      m_valid_d = 1'b1;
      m_last_d  = rsp_last_q;
      m_data_d  = bus.buf_rdata;
    end
    // A beat still pending when the frame is released is discarded.
    if (state_d != READY) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    rcv_ack_d  = (state_d == ACK);
    rx_ready_d = (state_d == READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rcvd_m_q     <= 1'b0;
      rcvd_s_q     <= 1'b0;
      nbytes_q     <= '0;
      rcv_ack_q    <= 1'b0;
      rx_ready_q   <= 1'b0;
      frame_cnt_q  <= '0;
      buf_rd_q     <= 1'b0;
      buf_addr_q   <= '0;
      rd_cpu_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      rsp_q        <= 1'b0;
      rsp_cpu_q    <= 1'b0;
      rsp_last_q   <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      dma_ptr_q    <= '0;
    end else begin
      state_q      <= state_d;
      rcvd_m_q     <= rcvd_m_d;
      rcvd_s_q     <= rcvd_s_d;
      nbytes_q     <= nbytes_d;
      rcv_ack_q    <= rcv_ack_d;
      rx_ready_q   <= rx_ready_d;
      frame_cnt_q  <= frame_cnt_d;
      buf_rd_q     <= buf_rd_d;
      buf_addr_q   <= buf_addr_d;
      rd_cpu_q     <= rd_cpu_d;
      rd_last_q    <= rd_last_d;
      rsp_q        <= rsp_d;
      rsp_cpu_q    <= rsp_cpu_d;
      rsp_last_q   <= rsp_last_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      dma_ptr_q    <= dma_ptr_d;
    end
  end

  assign nbytes         = nbytes_q;
  assign rcv_ack        = rcv_ack_q;
  assign rx_ready       = rx_ready_q;
  assign frame_cnt      = frame_cnt_q;
  assign bus.buf_rd     = buf_rd_q;
  assign bus.buf_addr   = buf_addr_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign bus.m_data     = m_data_q;

endmodule
